matrix_c_collector: RTL and testbench
=====================================

MATRIX_C_COLLECTOR -- requirements
Module: matrix_c_collector

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the square result matrix dimension and the lane count (power of two, >=2).
REQ-002 Parameter BITS, default 24, SHALL set the signed width of each result element.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port en, input, 1, SHALL mean: capture one skewed wavefront from d this cycle.
REQ-006 Port d, input, DEPTH x BITS signed unpacked array, SHALL carry the systolic array output lanes, with lane i feeding row i.
REQ-007 Port row, input, $clog2(DEPTH), SHALL be the readback row address.
REQ-008 Port col, input, $clog2(DEPTH), SHALL be the readback column address.
REQ-009 Port q, output, BITS signed, SHALL be the registered readback element C[row][col].
REQ-010 Port busy, output, 1, SHALL be high while state is CAPTURE.
REQ-011 Port done, output, 1, SHALL be high while state is DONE.

Function
REQ-012 Storage: DEPTH x DEPTH array of BITS-bit signed registers.
REQ-013 FSM states: IDLE, CAPTURE, DONE; wavefront counter t, range 0..2*DEPTH-2.
REQ-014 Capture rule: on a cycle with en=1 at counter value t, lane i SHALL be written to C[i][t-i] only when 0 <= t-i <= DEPTH-1; all other lanes are ignored.
REQ-015 IDLE or DONE with en=1: capture wavefront t=0, set t=1, go to CAPTURE (done drops the next cycle).
REQ-016 CAPTURE with en=1 and t<2*DEPTH-2: capture wavefront t, increment t.
REQ-017 CAPTURE with en=1 and t=2*DEPTH-2: capture the final wavefront, clear t to 0, go to DONE.
REQ-018 CAPTURE with en=0: stall; t, storage and state are held; no lane is written.
REQ-019 IDLE or DONE with en=0: hold state; storage is unchanged.
REQ-020 Capture latency: a full matrix takes exactly 2*DEPTH-1 en-high cycles; done rises on the edge that captures wavefront 2*DEPTH-2.
REQ-021 Readback: q SHALL update every cycle to C[row][col] as sampled at the edge, giving 1-cycle latency in every state.
REQ-022 Read during the write of the same element: q SHALL return the pre-write value, i.e. read-before-write.
REQ-023 A new capture started from DONE SHALL overwrite elements progressively; elements not yet rewritten keep the previous matrix values.
REQ-024 Element width: stored exactly as received, with no truncation or extension.

Reset
REQ-025 rst_n=0 at a rising edge SHALL zero all storage, q, t, busy and done, and select state IDLE.
REQ-026 Reset SHALL take priority over en, including mid-CAPTURE; the partial matrix is discarded.
REQ-027 The first edge with rst_n=1 SHALL behave as IDLE, so en=1 on that edge captures wavefront 0.

Configuration
REQ-028 With macro MATRIX_C_RELU_EN defined, each lane value SHALL be written as 0 when negative and unchanged otherwise.
REQ-029 Without MATRIX_C_RELU_EN, values SHALL be stored signed, unmodified; all other behaviour is identical in both builds.

Verification
REQ-030 Reset check: after reset, read all 64 (row,col) pairs -> q=0 at each, one cycle after the address is applied; busy=0, done=0.
REQ-031 Full capture: DEPTH=8, drive 15 en-high wavefronts with C[i][j]=16*i+j on the diagonal lanes -> done=1 after the 15th edge; readback gives C[3][5]=53 and C[7][7]=119.
REQ-032 Stall: deassert en for 4 cycles after wavefront 6 -> t holds at 7, busy stays 1, done stays 0; the final matrix is identical to the REQ-031 result.
REQ-033 Reset mid-capture: assert rst_n=0 after wavefront 9 -> next cycle state is IDLE and C[0][0] reads 0; a fresh 15-wavefront capture then completes correctly.
REQ-034 Read-before-write: hold row=2, col=0 while wavefront 2 writes 100 over the old value 34 -> q=34 on that edge and q=100 on the next.
REQ-035 ReLU build: capture C[1][1]=-5 and C[1][2]=7 -> without the macro reads give -5 and 7; with MATRIX_C_RELU_EN reads give 0 and 7.

Source files
------------

// File: rtl/matrix_c_collector.sv
// Collects skewed systolic wavefronts into a DEPTH x DEPTH result matrix with registered readback.
// Build macro MATRIX_C_RELU_EN clamps negative lane values to zero as they are written.
module matrix_c_collector #(
  parameter int DEPTH = 8,
  parameter int BITS  = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [BITS-1:0]     d [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   row,
  input  logic [$clog2(DEPTH)-1:0]   col,
  output logic signed [BITS-1:0]     q,
  output logic                       busy,
  output logic                       done
);

  localparam int TW = $clog2(2*DEPTH-1);
  localparam logic [TW-1:0] LAST = TW'(2*DEPTH-2);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d, t_cur;
  logic signed [BITS-1:0] c_q [DEPTH][DEPTH];
  logic signed [BITS-1:0] c_d [DEPTH][DEPTH];
  logic signed [BITS-1:0] q_q, q_d;
  logic signed [BITS-1:0] lane_v [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef MATRIX_C_RELU_EN
      lane_v[i] = d[i][BITS-1] ? '0 : d[i];
`else
      lane_v[i] = d[i];
`endif
    end
  end

  // A capture launched from IDLE or DONE always starts at wavefront 0.
  assign t_cur = (state_q == CAPTURE) ? t_q : '0;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d = CAPTURE;
          t_d     = TW'(1);
        end
      end
      CAPTURE: begin
        if (en) begin
          if (t_q == LAST) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lane i lands on the anti-diagonal element C[i][t-i].
  always_comb begin
    c_d = c_q;
    if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (int'(t_cur) == i + j) begin
            c_d[i][j] = lane_v[i];
          end
        end
      end
    end
  end

  assign q_d = c_q[row][col];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      q_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          c_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      q_q     <= q_d;
      c_q     <= c_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == CAPTURE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_matrix_c_collector.sv
// Directed bench for matrix_c_collector: reference matrix model plus a readback scoreboard.
// Honours MATRIX_C_RELU_EN when the design is built with it.
module tb_matrix_c_collector;

  localparam int DEPTH = 8;
  localparam int BITS  = 24;
  localparam int AW    = 3;
`ifdef MATRIX_C_RELU_EN
  localparam logic signed [BITS-1:0] EXP_C11 = '0;
`else
  localparam logic signed [BITS-1:0] EXP_C11 = -24'sd5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [BITS-1:0] d [DEPTH];
  logic [AW-1:0] row = '0;
  logic [AW-1:0] col = '0;
  logic signed [BITS-1:0] q;
  logic busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [BITS-1:0] m [DEPTH][DEPTH];
  logic signed [BITS-1:0] sb [$];
  int m_t;
  logic m_busy, m_done;
  int set_sel;

  matrix_c_collector #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d),
    .row(row), .col(col), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic signed [BITS-1:0] elem(int s, int i, int j);
    int v;
    v = 16*i + j;
    if (s == 1 && i == 2 && j == 0) v = 34;
    if (s == 2) begin
      if (i == 2 && j == 0) v = 100;
      if (i == 1 && j == 1) v = -5;
      if (i == 1 && j == 2) v = 7;
    end
    return BITS'(v);
  endfunction

  function automatic logic signed [BITS-1:0] stored(logic signed [BITS-1:0] v);
`ifdef MATRIX_C_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [BITS-1:0] got,
                       input logic signed [BITS-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input int r, input int c, input string tag);
    int tw;
    en  = e;
    row = AW'(r);
    col = AW'(c);
    tw  = m_busy ? m_t : 0;
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = tw - i;
      if (e && j >= 0 && j < DEPTH) d[i] = elem(set_sel, i, j);
      else d[i] = BITS'(-24'sd77 - i);
    end
    sb.push_back(m[r][c]);
    if (e) begin
      for (int i = 0; i < DEPTH; i++) begin
        int j;
        j = tw - i;
        if (j >= 0 && j < DEPTH) m[i][j] = stored(d[i]);
      end
      if (!m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; m_t = 1;
      end else if (m_t == 2*DEPTH-2) begin
        m_busy = 1'b0; m_done = 1'b1; m_t = 0;
      end else begin
        m_t++;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_q"}, q, sb.pop_front());
    check_bit({tag, "_busy"}, busy, m_busy);
    check_bit({tag, "_done"}, done, m_done);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_q"}, q, '0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++) m[i][j] = '0;
    m_t = 0; m_busy = 1'b0; m_done = 1'b0;
    sb.delete();
    rst_n = 1'b1;
    en    = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < DEPTH; c++) step(1'b0, r, c, tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) d[i] = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++) m[i][j] = '0;
    m_t = 0; m_busy = 1'b0; m_done = 1'b0;
    set_sel = 0;

    do_reset("rst0");
    read_all("rst_read");

    for (int w = 0; w < 2*DEPTH-1; w++) step(1'b1, 0, 0, "cap0");
    check_bit("cap0_done", done, 1'b1);
    step(1'b0, 3, 5, "rd35");
    check("c35", q, 24'sd53);
    step(1'b0, 7, 7, "rd77");
    check("c77", q, 24'sd119);
    read_all("rb0");

    for (int w = 0; w < 7; w++) step(1'b1, 4, 4, "stl_a");
    for (int k = 0; k < 4; k++) step(1'b0, 3, 5, "stall");
    check_bit("stall_busy", busy, 1'b1);
    check_bit("stall_done", done, 1'b0);
    for (int w = 7; w < 2*DEPTH-1; w++) step(1'b1, 5, 6, "stl_b");
    check_bit("stl_done", done, 1'b1);
    read_all("rb_stall");

    set_sel = 1;
    for (int w = 0; w < 10; w++) step(1'b1, 1, 1, "part");
    do_reset("rst_mid");
    step(1'b1, 0, 0, "fresh_w0");
    check("c00_after_rst", q, '0);
    for (int w = 1; w < 2*DEPTH-1; w++) step(1'b1, 0, 0, "cap1");
    read_all("rb1");

    set_sel = 2;
    step(1'b1, 2, 0, "rbw_w0");
    step(1'b1, 2, 0, "rbw_w1");
    step(1'b1, 2, 0, "rbw_w2");
    check("rbw_pre", q, 24'sd34);
    step(1'b1, 2, 0, "rbw_w3");
    check("rbw_post", q, 24'sd100);
    step(1'b1, 7, 7, "keep_w4");
    step(1'b1, 7, 7, "keep_w5");
    check("keep_c77", q, 24'sd119);
    for (int w = 6; w < 2*DEPTH-1; w++) step(1'b1, 6, 1, "cap2");
    read_all("rb2");
    step(1'b0, 1, 1, "rd11");
    check("relu_c11", q, EXP_C11);
    step(1'b0, 1, 2, "rd12");
    check("relu_c12", q, 24'sd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
